dram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single AXI-Lite bridge port in front of the pseudo DRAM in the Online Shopping Platform. It accepts read/write requests for one 64-bit user record per transaction from two clients (for example the buyer-side and seller-side lookup engines of OS). It serialises them onto the bridge's C_* handshake with at most one transaction outstanding, and routes the bridge response back to the requester that issued it.

---
 rtl/dram_port_arbiter.sv | 93 +++++++++
 tb/tb_dram_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: two-requester arbiter/sequencer onto the single C_* bridge port, one transaction outstanding.
// Define DRAM_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module dram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    input  logic [1:0]          req_r_wb,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                C_in_valid,
    output logic [ADDR_W-1:0]   C_addr,
    output logic [DATA_W-1:0]   C_data_w,
    output logic                C_r_wb,
    input  logic                C_out_valid,
    input  logic [DATA_W-1:0]   C_data_r,
    output logic                arb_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arbState;
    arbState state, nextState;
    logic [1:0] winner;
    logic accept;
    logic grantIdx;
    logic rwbReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic [DATA_W-1:0] rspReg;
`ifdef DRAM_ARB_RR_EN
    logic lastGrant;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lastGrant <= 1'b1;
        else if (accept) lastGrant <= req_ready[1];
    // a lone requester's valid mask is already its one-hot grant
    assign winner = (&req_valid) ? (lastGrant ? 2'b01 : 2'b10) : req_valid;
`else
    assign winner = req_valid[0] ? 2'b01 : req_valid;
`endif
    always_comb begin
        nextState  = state;
        req_ready  = 2'b00;
        C_in_valid = 1'b0;
        rsp_valid  = 2'b00;
        rsp_data   = '0;
        case (state)
            IDLE: begin
                req_ready = winner;
                nextState = (|winner) ? ISSUE : IDLE;
            end
            ISSUE: begin
                C_in_valid = 1'b1;
                nextState  = WAIT;
            end
            WAIT: nextState = C_out_valid ? RESP : WAIT;
            RESP: begin
                rsp_valid = grantIdx ? 2'b10 : 2'b01;
                rsp_data  = rspReg;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end
    assign accept   = |req_ready;
    assign C_addr   = addrReg;
    assign C_data_w = wdataReg;
    assign C_r_wb   = rwbReg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grantIdx <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            rwbReg   <= 1'b0;
            rspReg   <= '0;
            arb_err  <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                grantIdx <= req_ready[1];
                addrReg  <= req_ready[1] ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                wdataReg <= req_ready[1] ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                rwbReg   <= req_ready[1] ? req_r_wb[1] : req_r_wb[0];
            end
            if (state == WAIT && C_out_valid) rspReg <= rwbReg ? C_data_r : '0;
            // a completion outside WAIT has no transaction to belong to
            if (C_out_valid && state != WAIT) arb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: vector table plus randomized transactions checked against a grant-order model.
// Expected grant order follows DRAM_ARB_RR_EN when it is defined for the build.
module tb_dram_port_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [15:0]  req_addr;
    logic [127:0] req_wdata;
    logic [1:0]   req_r_wb;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic         C_in_valid;
    logic [7:0]   C_addr;
    logic [63:0]  C_data_w;
    logic         C_r_wb;
    logic         C_out_valid;
    logic [63:0]  C_data_r;
    logic         arb_err;
    int checks = 0;
    int failures = 0;
    int mLast = 1;

    dram_port_arbiter #(.ADDR_W(8), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_r_wb(req_r_wb),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .C_in_valid(C_in_valid), .C_addr(C_addr), .C_data_w(C_data_w), .C_r_wb(C_r_wb),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [7:0]  a0, a1;
        logic [63:0] w0, w1;
        logic [1:0]  rwb;
        int          lat;
        logic [63:0] rdata;
        logic [1:0]  expGrant;
    } vecT;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] modelGrant(input logic [1:0] v);
        if (v == 2'b01) return 2'b01;
        if (v == 2'b10) return 2'b10;
        if (v == 2'b00) return 2'b00;
`ifdef DRAM_ARB_RR_EN
        return (mLast == 1) ? 2'b01 : 2'b10;
`else
        return 2'b01;
`endif
    endfunction

    task automatic checkResetOutputs(input string nm);
        chk({nm, " req_ready"}, req_ready, 0);
        chk({nm, " rsp_valid"}, rsp_valid, 0);
        chk({nm, " rsp_data"}, rsp_data, 0);
        chk({nm, " C_in_valid"}, C_in_valid, 0);
        chk({nm, " C_addr"}, C_addr, 0);
        chk({nm, " C_data_w"}, C_data_w, 0);
        chk({nm, " C_r_wb"}, C_r_wb, 0);
        chk({nm, " arb_err"}, arb_err, 0);
    endtask

    // full transaction from the IDLE cycle to the next IDLE cycle, bridge answering lat cycles after ISSUE
    task automatic txn(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [63:0] w0, input logic [63:0] w1, input logic [1:0] rwb,
                       input int lat, input logic [63:0] rd, input logic [1:0] eg, input string nm);
        int w;
        logic [7:0] ea;
        logic [63:0] ew, er;
        w  = eg[1] ? 1 : 0;
        ea = w ? a1 : a0;
        ew = w ? w1 : w0;
        er = rwb[w] ? rd : 64'd0;
        req_valid = v;
        req_addr  = {a1, a0};
        req_wdata = {w1, w0};
        req_r_wb  = rwb;
        @(negedge clk);
        chk({nm, " grant"}, req_ready, eg);
        chk({nm, " idle rsp_valid"}, rsp_valid, 0);
        chk({nm, " idle C_in_valid"}, C_in_valid, 0);
        tick();
        @(negedge clk);
        chk({nm, " issue C_in_valid"}, C_in_valid, 1);
        chk({nm, " issue C_addr"}, C_addr, ea);
        chk({nm, " issue C_data_w"}, C_data_w, ew);
        chk({nm, " issue C_r_wb"}, C_r_wb, rwb[w]);
        chk({nm, " issue req_ready"}, req_ready, 0);
        for (int i = 1; i < lat; i++) begin
            tick();
            @(negedge clk);
            chk({nm, " wait C_in_valid"}, C_in_valid, 0);
            chk({nm, " wait req_ready"}, req_ready, 0);
            chk({nm, " wait rsp_valid"}, rsp_valid, 0);
            chk({nm, " wait C_data_w"}, C_data_w, ew);
        end
        tick();
        C_out_valid = 1'b1;
        C_data_r    = rd;
        @(negedge clk);
        chk({nm, " done rsp_valid"}, rsp_valid, 0);
        chk({nm, " done C_addr"}, C_addr, ea);
        chk({nm, " done C_data_w"}, C_data_w, ew);
        tick();
        C_out_valid = 1'b0;
        C_data_r    = {$urandom, $urandom};
        @(negedge clk);
        chk({nm, " rsp_valid"}, rsp_valid, eg);
        chk({nm, " rsp_data"}, rsp_data, er);
        chk({nm, " resp req_ready"}, req_ready, 0);
        tick();
        mLast = w;
    endtask

    vecT vecs[8];

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_addr = '0;
        req_wdata = '0;
        req_r_wb = 2'b00;
        C_out_valid = 1'b0;
        C_data_r = '0;
        vecs[0] = '{2'b01, 8'h05, 8'h00, 64'h0, 64'h0, 2'b01, 4, 64'h0123_4567_89AB_CDEF, 2'b01};
        vecs[1] = '{2'b10, 8'h00, 8'hFF, 64'h0, 64'hDEAD_BEEF_0000_0001, 2'b00, 3, 64'h5555_AAAA_5555_AAAA, 2'b10};
`ifdef DRAM_ARB_RR_EN
        vecs[2] = '{2'b11, 8'h11, 8'h22, 64'h1111, 64'h2222, 2'b01, 2, 64'hCAFE_0000_0000_0002, 2'b01};
        vecs[3] = '{2'b11, 8'h11, 8'h22, 64'h1111, 64'h2222, 2'b01, 2, 64'hCAFE_0000_0000_0003, 2'b10};
        vecs[4] = '{2'b11, 8'h33, 8'h44, 64'h3333, 64'h4444, 2'b10, 2, 64'hCAFE_0000_0000_0004, 2'b01};
        vecs[5] = '{2'b11, 8'h33, 8'h44, 64'h3333, 64'h4444, 2'b10, 2, 64'hCAFE_0000_0000_0005, 2'b10};
`else
        vecs[2] = '{2'b11, 8'h11, 8'h22, 64'h1111, 64'h2222, 2'b01, 2, 64'hCAFE_0000_0000_0002, 2'b01};
        vecs[3] = '{2'b11, 8'h11, 8'h22, 64'h1111, 64'h2222, 2'b01, 2, 64'hCAFE_0000_0000_0003, 2'b01};
        vecs[4] = '{2'b11, 8'h33, 8'h44, 64'h3333, 64'h4444, 2'b10, 2, 64'hCAFE_0000_0000_0004, 2'b01};
        vecs[5] = '{2'b11, 8'h33, 8'h44, 64'h3333, 64'h4444, 2'b10, 2, 64'hCAFE_0000_0000_0005, 2'b01};
`endif
        vecs[6] = '{2'b01, 8'h7A, 8'h00, 64'h0, 64'h0, 2'b01, 1, 64'hFEED_FACE_1234_5678, 2'b01};
        vecs[7] = '{2'b10, 8'h00, 8'h80, 64'h0, 64'h8888_7777_6666_5555, 2'b00, 1, 64'h1, 2'b10};
        #2;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 8; k++)
            txn(vecs[k].valid, vecs[k].a0, vecs[k].a1, vecs[k].w0, vecs[k].w1, vecs[k].rwb,
                vecs[k].lat, vecs[k].rdata, vecs[k].expGrant, $sformatf("vec%0d", k));
        req_valid = 2'b00;
        @(negedge clk);
        chk("no error yet arb_err", arb_err, 0);
        tick();
        C_out_valid = 1'b1;
        C_data_r = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        chk("spurious rsp_valid", rsp_valid, 0);
        tick();
        C_out_valid = 1'b0;
        @(negedge clk);
        chk("spurious arb_err", arb_err, 1);
        chk("spurious rsp_valid after", rsp_valid, 0);
        tick();
        txn(2'b01, 8'h42, 8'h24, 64'h0, 64'h0, 2'b01, 2, 64'h0BAD_F00D_0000_0042, 2'b01, "after spurious");
        req_valid = 2'b01;
        req_addr = {8'h00, 8'h99};
        req_r_wb = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midwait reset");
        mLast = 1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        C_out_valid = 1'b1;
        tick();
        C_out_valid = 1'b0;
        @(negedge clk);
        chk("late completion arb_err", arb_err, 1);
        chk("late completion rsp_valid", rsp_valid, 0);
        tick();
        txn(2'b11, 8'h01, 8'h02, 64'h10, 64'h20, 2'b11, 2, 64'h7777_0000_0000_7777, 2'b01, "post reset contention");
        for (int k = 0; k < 40; k++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            txn(v, 8'($urandom), 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                2'($urandom), $urandom_range(1, 5), {$urandom, $urandom}, modelGrant(v), $sformatf("rand%0d", k));
        end
        req_valid = 2'b00;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
